// File: rtl/storm_pio_loader.sv
// Host PIO loader: 4-phase strobe/ack commands write IRAM/DRAM and gate the core reset.
// Write pulse is SYNC_STAGES+1 cycles after iStb rises; oAck holds until the synchronized strobe drops.
module storm_pio_loader #(
  parameter int DATA_W      = 16,
  parameter int IADDR_W     = 9,
  parameter int DADDR_W     = 10,
  parameter int SYNC_STAGES = 2
) (
  input  logic               iClk,
  input  logic               iRst,
  input  logic               iStb,
  input  logic [1:0]         iCtrl,
  input  logic [DATA_W-1:0]  iPData,
  output logic               oAck,
  output logic [IADDR_W-1:0] oIAddr,
  output logic [DATA_W-1:0]  oIData,
  output logic               oIWe,
  output logic [DADDR_W-1:0] oDAddr,
  output logic [DATA_W-1:0]  oDData,
  output logic               oDWe,
  output logic               oCoreRst,
  output logic               oErr
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    ACK  = 2'd2
  } state_t;

  localparam logic [1:0] CMD_SETADDR = 2'b00;
  localparam logic [1:0] CMD_WRITE   = 2'b01;
  localparam logic [1:0] CMD_RUN     = 2'b10;
  localparam logic [1:0] CMD_HALT    = 2'b11;

  localparam int BLANK_W = $clog2(SYNC_STAGES + 2);

  state_t               state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                 stb_prev_q;
  logic [BLANK_W-1:0]   blank_q;
  logic [1:0]           cmd_q;
  logic [DADDR_W-1:0]   ptr_q;
  logic [DADDR_W-1:0]   ptr_inc_d;
  logic                 tgt_q;
  logic                 ack_q;
  logic [IADDR_W-1:0]   iaddr_q;
  logic [DATA_W-1:0]    idata_q;
  logic                 iwe_q;
  logic [DADDR_W-1:0]   daddr_q;
  logic [DATA_W-1:0]    ddata_q;
  logic                 dwe_q;
  logic                 core_rst_q;
  logic                 err_q;

  logic stb_s;
  logic rise;

  assign stb_s = sync_q[SYNC_STAGES-1];
  // The synchronizer clears on reset, so a strobe still held high afterwards would look
  // like a fresh rise; edges are ignored until the chain has settled on the real level.
  assign rise  = stb_s & ~stb_prev_q & (blank_q == '0);

  always_comb begin
    ptr_inc_d = ptr_q + DADDR_W'(1);
    if (!tgt_q) begin
      ptr_inc_d = {{(DADDR_W-IADDR_W){1'b0}}, ptr_q[IADDR_W-1:0] + IADDR_W'(1)};
    end
  end

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      state_q    <= IDLE;
      sync_q     <= '0;
      stb_prev_q <= 1'b0;
      blank_q    <= BLANK_W'(SYNC_STAGES + 1);
      cmd_q      <= CMD_SETADDR;
      ptr_q      <= '0;
      tgt_q      <= 1'b0;
      ack_q      <= 1'b0;
      iaddr_q    <= '0;
      idata_q    <= '0;
      iwe_q      <= 1'b0;
      daddr_q    <= '0;
      ddata_q    <= '0;
      dwe_q      <= 1'b0;
      core_rst_q <= 1'b1;
      err_q      <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], iStb};
      stb_prev_q <= stb_s;
      if (blank_q != '0) begin
        blank_q <= blank_q - BLANK_W'(1);
      end
      iwe_q <= 1'b0;
      dwe_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (rise) begin
            cmd_q   <= iCtrl;
            state_q <= EXEC;
            // Write strobes are registered here so the pulse is visible during EXEC.
            case (iCtrl)
              CMD_SETADDR: begin
                tgt_q <= iPData[DATA_W-1];
                ptr_q <= iPData[DADDR_W-1:0];
              end
              CMD_WRITE: begin
                if (core_rst_q) begin
                  if (!tgt_q) begin
                    iwe_q   <= 1'b1;
                    iaddr_q <= ptr_q[IADDR_W-1:0];
                    idata_q <= iPData;
                  end else begin
                    dwe_q   <= 1'b1;
                    daddr_q <= ptr_q;
                    ddata_q <= iPData;
                  end
                  ptr_q <= ptr_inc_d;
                end else begin
                  err_q <= 1'b1;
                end
              end
              default: ;
            endcase
          end
        end
        EXEC: begin
          state_q <= ACK;
          ack_q   <= 1'b1;
          if (cmd_q == CMD_RUN) begin
            core_rst_q <= 1'b0;
          end else if (cmd_q == CMD_HALT) begin
            core_rst_q <= 1'b1;
          end
        end
        ACK: begin
          if (!stb_s) begin
            ack_q   <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign oAck     = ack_q;
  assign oIAddr   = iaddr_q;
  assign oIData   = idata_q;
  assign oIWe     = iwe_q;
  assign oDAddr   = daddr_q;
  assign oDData   = ddata_q;
  assign oDWe     = dwe_q;
  assign oCoreRst = core_rst_q;
  assign oErr     = err_q;

endmodule
